// File: rtl/locked_alu_pkg.sv
// Shared types for the key-locked pipelined ALU: op codes, key FSM states, flags.
package locked_alu_pkg;

    // Codes 10..15 are unnamed and produce a zero result.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        KS_LOCKED   = 2'd0,
        KS_UNLOCKED = 2'd1,
        KS_LOCKOUT  = 2'd2
    } key_state_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/locked_alu_keyfsm.sv
// Key state machine: compares loaded keys, counts wrong attempts and locks out
// permanently (until reset) after MAX_FAIL consecutive failures.
module locked_alu_keyfsm
    import locked_alu_pkg::*;
#(
    parameter int               KEY_W      = 8,
    parameter logic [KEY_W-1:0] GOLDEN_KEY = 8'h0F,
    parameter int               MAX_FAIL   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    output key_state_e       state,
    output logic             unlocked,
    output logic             lockout
);

    localparam int CNT_W = $clog2(MAX_FAIL + 1);
    localparam logic [CNT_W-1:0] FAIL_LIMIT = CNT_W'(MAX_FAIL);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] fail_inc;
    logic             key_match;

    // Next-state logic: only cycles with key_load change anything; LOCKOUT is terminal.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        key_match  = (key_in == GOLDEN_KEY);
        fail_inc   = (fail_cnt_q == FAIL_LIMIT) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);

        if (key_load && state_q != KS_LOCKOUT) begin
            if (key_match) begin
                state_d    = KS_UNLOCKED;
                fail_cnt_d = '0;
            end else begin
                fail_cnt_d = fail_inc;
                state_d    = (fail_inc == FAIL_LIMIT) ? KS_LOCKOUT : KS_LOCKED;
            end
        end
    end

    // State and fail counter registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            state_q    <= KS_LOCKED;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign state    = state_q;
    assign unlocked = (state_q == KS_UNLOCKED);
    assign lockout  = (state_q == KS_LOCKOUT);

endmodule

// File: rtl/locked_alu_pipe.sv
// Two-stage key-locked ALU with valid/ready on both sides. Operands are XORed
// with OBF_MASK at capture unless the key FSM is UNLOCKED at that moment.
module locked_alu_pipe
    import locked_alu_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               KEY_W      = 8,
    parameter logic [KEY_W-1:0] GOLDEN_KEY = 8'h0F,
    parameter logic [XLEN-1:0]  OBF_MASK   = 32'hA5A5_A5A5,
    parameter int               MAX_FAIL   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    output logic             unlocked,
    output logic             lockout,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int SH_W = $clog2(XLEN);

    key_state_e key_state;

    locked_alu_keyfsm #(
        .KEY_W      (KEY_W),
        .GOLDEN_KEY (GOLDEN_KEY),
        .MAX_FAIL   (MAX_FAIL)
    ) u_keyfsm (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_in   (key_in),
        .state    (key_state),
        .unlocked (unlocked),
        .lockout  (lockout)
    );

    // Stage registers.
    logic            s1_valid_q, s1_valid_d;
    logic [3:0]      s1_op_q, s1_op_d;
    logic [XLEN-1:0] s1_a_q, s1_a_d;
    logic [XLEN-1:0] s1_b_q, s1_b_d;
    logic            s2_valid_q, s2_valid_d;
    logic [XLEN-1:0] s2_result_q, s2_result_d;
    alu_flags_t      s2_flags_q, s2_flags_d;

    // Datapath intermediates.
    logic            en;
    logic            accept;
    logic [XLEN-1:0] mask;
    logic            is_add, is_sub;
    logic [XLEN-1:0] b_op;
    logic [XLEN:0]   sum;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_result;
    alu_flags_t      alu_flags;

    // Both stages advance together; a full S2 that is not being drained freezes the pipe.
    assign en       = !s2_valid_q || out_ready;
    assign in_ready = en && (key_state != KS_LOCKOUT) && rst;
    assign accept   = in_valid && in_ready;
    // The mask decision uses the registered key state, so a same-cycle key_load does not affect it.
    assign mask     = (key_state == KS_UNLOCKED) ? '0 : OBF_MASK;

    // Stage 1 capture: masked operands and raw op.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (en) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_op_d = op;
                s1_a_d  = a ^ mask;
                s1_b_d  = b ^ mask;
            end
        end
    end

    // ALU on stage 1 contents; SUB shares the adder as a + ~b + 1.
    always_comb begin
        is_add     = (s1_op_q == OP_ADD);
        is_sub     = (s1_op_q == OP_SUB);
        b_op       = is_sub ? ~s1_b_q : s1_b_q;
        sum        = {1'b0, s1_a_q} + {1'b0, b_op} + {{XLEN{1'b0}}, is_sub};
        shamt      = s1_b_q[SH_W-1:0];
        alu_result = '0;
        case (alu_op_e'(s1_op_q))
            OP_ADD,
            OP_SUB:  alu_result = sum[XLEN-1:0];
            OP_AND:  alu_result = s1_a_q & s1_b_q;
            OP_OR:   alu_result = s1_a_q | s1_b_q;
            OP_XOR:  alu_result = s1_a_q ^ s1_b_q;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (s1_a_q < s1_b_q)};
            OP_SLL:  alu_result = s1_a_q << shamt;
            OP_SRL:  alu_result = s1_a_q >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(s1_a_q) >>> shamt);
            default: alu_result = '0;
        endcase
        alu_flags.zero     = (alu_result == '0);
        alu_flags.negative = alu_result[XLEN-1];
        alu_flags.carry    = (is_add || is_sub) && sum[XLEN];
        alu_flags.overflow = (is_add || is_sub)
                             && (s1_a_q[XLEN-1] == b_op[XLEN-1])
                             && (sum[XLEN-1] != s1_a_q[XLEN-1]);
    end

    // Stage 2 capture: result and flags of whatever S1 holds.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = alu_result;
                s2_flags_d  = alu_flags;
            end
        end
    end

    // Pipeline registers; reset clears valids and data so outputs read zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign zero      = s2_flags_q.zero;
    assign negative  = s2_flags_q.negative;
    assign carry     = s2_flags_q.carry;
    assign overflow  = s2_flags_q.overflow;

endmodule

// File: tb/tb_locked_alu_pipe.sv
// Scoreboard bench for locked_alu_pipe: expected results are queued at accept
// time from a behavioural model and compared in order as results are consumed.
module tb_locked_alu_pipe;

    localparam logic [31:0] MASK = 32'hA5A5_A5A5;
    localparam logic [7:0]  KEY  = 8'h0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [7:0]  key_in;
    logic        unlocked, lockout;
    logic        in_valid, in_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        zero, negative, carry, overflow;

    locked_alu_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;   // {zero, negative, carry, overflow}
    } exp_t;

    exp_t scb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_state = 0;      // 0 locked, 1 unlocked, 2 lockout
    int   m_fail  = 0;
    bit   accepted;
    int   outputs_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        exp_t        e;
        logic [32:0] w;
        longint      s;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        w = '0;
        case (mop)
            4'd0: begin
                w = {1'b0, ma} + {1'b0, mb};
                s = longint'($signed(ma)) + longint'($signed(mb));
                c = w[32];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.res = w[31:0];
            end
            4'd1: begin
                w = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
                s = longint'($signed(ma)) - longint'($signed(mb));
                c = w[32];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.res = w[31:0];
            end
            4'd2: e.res = ma & mb;
            4'd3: e.res = ma | mb;
            4'd4: e.res = ma ^ mb;
            4'd5: e.res = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
            4'd6: e.res = (ma < mb) ? 32'd1 : 32'd0;
            4'd7: e.res = ma << mb[4:0];
            4'd8: e.res = ma >> mb[4:0];
            4'd9: e.res = 32'($signed(ma) >>> mb[4:0]);
            default: e.res = 32'd0;
        endcase
        e.flg = {(e.res == 32'd0), e.res[31], c, v};
        return e;
    endfunction

    // One clock: sample handshakes before the edge, advance the key model at the edge.
    task automatic step();
        exp_t e;
        #1;
        accepted = in_valid && in_ready;
        if (accepted) begin
            if (m_state == 1) scb.push_back(model(op, a, b));
            else              scb.push_back(model(op, a ^ MASK, b ^ MASK));
        end
        if (out_valid && out_ready) begin
            outputs_seen++;
            check("output expected", 64'(scb.size() != 0), 64'd1);
            if (scb.size() != 0) begin
                e = scb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("flags", 64'({zero, negative, carry, overflow}), 64'(e.flg));
            end
        end
        @(posedge clk);
        if (key_load && m_state != 2) begin
            if (key_in == KEY) begin
                m_state = 1;
                m_fail  = 0;
            end else begin
                m_fail  = (m_fail < 3) ? m_fail + 1 : 3;
                m_state = (m_fail >= 3) ? 2 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] s_op, input logic [31:0] s_a, input logic [31:0] s_b);
        in_valid = 1'b1;
        op = s_op;
        a  = s_a;
        b  = s_b;
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) step();
        check("accept", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && scb.size() > 0; k++) step();
        check("drain empty", 64'(scb.size()), 64'd0);
    endtask

    task automatic pulse_reset(input bit checks);
        #2 rst = 1'b0;
        #1;
        if (checks) begin
            check("rst out_valid", 64'(out_valid), 64'd0);
            check("rst unlocked", 64'(unlocked), 64'd0);
            check("rst lockout", 64'(lockout), 64'd0);
            check("rst in_ready", 64'(in_ready), 64'd0);
            check("rst result", 64'(result), 64'd0);
        end
        scb.delete();
        m_state = 0;
        m_fail  = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    logic [3:0]  t_op [10] = '{4'd1, 4'd5, 4'd6, 4'd9, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd12};
    logic [31:0] t_a  [10] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_1234,
                               32'h0F0F_0000, 32'hFFFF_0000, 32'd1, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] t_b  [10] = '{32'd5, 32'd1, 32'd1, 32'd4, 32'h0FF0_FF00,
                               32'h0000_00F0, 32'h0F0F_0F0F, 32'd33, 32'd31, 32'h9ABC_DEF0};

    initial begin
        rst = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0;
        op = '0; a = '0; b = '0; out_ready = 1'b1; outputs_seen = 0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'({zero, negative, carry, overflow}), 64'd0);
        check("reset unlocked", 64'(unlocked), 64'd0);
        check("reset lockout", 64'(lockout), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // No key: masked ADD, latency of two edges from presentation.
        in_valid = 1'b1; op = 4'd0; a = 32'd5; b = 32'd3;
        step();
        check("accept locked", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        check("latency s1", 64'(out_valid), 64'd0);
        step();
        check("latency s2", 64'(out_valid), 64'd1);
        check("masked add", 64'(result), 64'h4B4B_4B46);
        drain();
        check("still locked", 64'(unlocked), 64'd0);

        // Unlock, then signed overflow on ADD.
        key_load = 1'b1; key_in = KEY;
        step();
        key_load = 1'b0;
        check("unlocked", 64'(unlocked), 64'd1);
        send(4'd0, 32'h7FFF_FFFF, 32'd1);
        drain();

        // Back-to-back unlocked ops.
        for (int i = 0; i < 10; i++) send(t_op[i], t_a[i], t_b[i]);
        drain();

        // Backpressure: fill both stages, hold out_ready low.
        outputs_seen = 0;
        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd2);
        send(4'd1, 32'd10, 32'd3);
        in_valid = 1'b1; op = 4'd4; a = 32'hAAAA_0000; b = 32'h00FF_00FF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall in_ready", 64'(in_ready), 64'd0);
            check("stall out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        send(4'd4, 32'hAAAA_0000, 32'h00FF_00FF);
        send(4'd3, 32'h0000_F000, 32'h0000_000F);
        drain();
        check("bp count", 64'(outputs_seen), 64'd4);

        // Key abuse: relock, then lockout with an op in flight.
        key_load = 1'b1; key_in = 8'h11;
        step();
        check("relock unlocked", 64'(unlocked), 64'd0);
        check("relock lockout", 64'(lockout), 64'd0);
        key_in = 8'h22;
        step();
        check("2nd wrong lockout", 64'(lockout), 64'd0);
        key_in = 8'h33; in_valid = 1'b1; op = 4'd0; a = 32'd5; b = 32'd3;
        step();
        check("accept before lockout", 64'(accepted), 64'd1);
        key_load = 1'b0; in_valid = 1'b0;
        check("lockout", 64'(lockout), 64'd1);
        check("lockout in_ready", 64'(in_ready), 64'd0);
        drain();
        key_load = 1'b1; key_in = KEY; in_valid = 1'b1;
        step();
        check("lockout no accept", 64'(accepted), 64'd0);
        key_load = 1'b0;
        step();
        in_valid = 1'b0;
        check("key ignored unlocked", 64'(unlocked), 64'd0);
        check("key ignored lockout", 64'(lockout), 64'd1);
        check("lockout in_ready hold", 64'(in_ready), 64'd0);
        pulse_reset(1'b1);

        // Same cycle key_load and accept: this op masked, next one not.
        key_load = 1'b1; key_in = KEY; in_valid = 1'b1; op = 4'd0; a = 32'd5; b = 32'd3;
        step();
        check("same-cycle accept", 64'(accepted), 64'd1);
        key_load = 1'b0;
        send(4'd0, 32'd5, 32'd3);
        drain();

        // Reset in the middle of a stalled stream.
        out_ready = 1'b0;
        send(4'd2, 32'hFFFF_FFFF, 32'h1234_5678);
        send(4'd0, 32'd40, 32'd2);
        pulse_reset(1'b1);
        out_ready = 1'b1;
        check("rekey required", 64'(unlocked), 64'd0);
        send(4'd0, 32'd5, 32'd3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
